// File: rtl/mem_bist_pkg.sv
// Shared types and helpers for the memory BIST initiator: FSM state encoding,
// bus/counter widths and the address-derived test pattern.
package mem_bist_pkg;

    localparam int BUS_W = 32;
    localparam int ERR_W = 16;
    localparam int IDX_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_REQ,
        ST_WR_REL,
        ST_RD_REQ,
        ST_RD_REL,
        ST_FIN
    } state_t;

    // Pattern for word address a: complement in the upper half, a in the lower half.
    function automatic logic [BUS_W-1:0] pat(input logic [15:0] a);
        return {~a, a};
    endfunction

endpackage

// File: rtl/mem_bist_watchdog.sv
// Reloadable down-counter; flags expiry on the TIMEOUT-th active cycle after a reload.
// Latency: combinational expire flag, counter updates every active cycle.
// Backpressure: none; free-running while i_active is high.
module mem_bist_watchdog #(
    parameter int TIMEOUT = 1023
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_active,
    input  logic i_reload,
    output logic o_expired
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cur;

    // The reload cycle itself counts as the first cycle in the new state.
    assign w_cur     = i_reload ? RELOAD : r_cnt;
    assign o_expired = i_active && (w_cur == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_active && (w_cur != '0)) begin
            r_cnt <= w_cur - CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_bist.sv
// Memory BIST initiator: writes pat(addr) over a word range via a 4-phase bus, reads back, compares.
// Latency: >= 2 cycles per word per phase plus responder latency; result on done one cycle after FIN.
// Backpressure: each request is held until mem_ack; watchdog aborts. MEM_BIST_INVERT_PASS_EN adds a ~pat pass.
module mem_bist
    import mem_bist_pkg::*;
#(
    parameter logic [BUS_W-1:0] ADDR_BASE = 32'h0000_0000,
    parameter int               WORDS     = 256,
    parameter logic [BUS_W-1:0] ADDR_STEP = 32'd4,
    parameter int               TIMEOUT   = 1023
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    output logic             mem_read,
    output logic             mem_write,
    input  logic             mem_ack,
    output logic [BUS_W-1:0] mem_addr,
    output logic [BUS_W-1:0] mem_write_data,
    input  logic [BUS_W-1:0] mem_read_data,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [ERR_W-1:0] err_count,
    output logic [BUS_W-1:0] fail_addr,
    output logic [BUS_W-1:0] fail_data
);

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(WORDS - 1);
    localparam logic [15:0]      BASE_WORD = ADDR_BASE[17:2];

    state_t           r_state;
    logic             r_start_d;
    logic             r_mem_read;
    logic             r_mem_write;
    logic [IDX_W-1:0] r_idx;
    logic [BUS_W-1:0] r_addr;
    logic [BUS_W-1:0] r_wdata;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic             r_timeout;
    logic [ERR_W-1:0] r_err;
    logic [BUS_W-1:0] r_fail_addr;
    logic [BUS_W-1:0] r_fail_data;
    logic             r_wd_reload;

    logic             w_start_edge;
    logic             w_wd_active;
    logic             w_wd_expired;
    logic [BUS_W-1:0] w_addr_inc;
    logic [BUS_W-1:0] w_inv_mask;

`ifdef MEM_BIST_INVERT_PASS_EN
    logic r_inv;
    assign w_inv_mask = {BUS_W{r_inv}};
`else
    assign w_inv_mask = '0;
`endif

    assign w_start_edge = start && !r_start_d;
    assign w_addr_inc   = r_addr + ADDR_STEP;
    assign w_wd_active  = (r_state == ST_WR_REQ) || (r_state == ST_WR_REL) ||
                          (r_state == ST_RD_REQ) || (r_state == ST_RD_REL);

    mem_bist_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_active  (w_wd_active),
        .i_reload  (r_wd_reload),
        .o_expired (w_wd_expired)
    );

    // r_wdata always holds the pattern expected at r_addr; it doubles as the read-back reference.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_start_d   <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_idx       <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_timeout   <= 1'b0;
            r_err       <= '0;
            r_fail_addr <= '0;
            r_fail_data <= '0;
            r_wd_reload <= 1'b0;
`ifdef MEM_BIST_INVERT_PASS_EN
            r_inv       <= 1'b0;
`endif
        end else begin
            r_start_d   <= start;
            r_wd_reload <= 1'b0;
            if (w_wd_expired) begin
                r_mem_read  <= 1'b0;
                r_mem_write <= 1'b0;
                r_timeout   <= 1'b1;
                r_state     <= ST_FIN;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_start_edge) begin
                            r_err       <= '0;
                            r_fail_addr <= '0;
                            r_fail_data <= '0;
                            r_timeout   <= 1'b0;
                            r_done      <= 1'b0;
                            r_pass      <= 1'b0;
                            r_busy      <= 1'b1;
                            r_idx       <= '0;
                            r_addr      <= ADDR_BASE;
                            r_wdata     <= pat(BASE_WORD);
                            r_mem_write <= 1'b1;
                            r_wd_reload <= 1'b1;
                            r_state     <= ST_WR_REQ;
`ifdef MEM_BIST_INVERT_PASS_EN
                            r_inv       <= 1'b0;
`endif
                        end
                    end
                    ST_WR_REQ: begin
                        if (mem_ack) begin
                            r_mem_write <= 1'b0;
                            r_wd_reload <= 1'b1;
                            r_state     <= ST_WR_REL;
                        end
                    end
                    ST_WR_REL: begin
                        if (!mem_ack) begin
                            r_wd_reload <= 1'b1;
                            if (r_idx == LAST_IDX) begin
                                r_idx      <= '0;
                                r_addr     <= ADDR_BASE;
                                r_wdata    <= pat(BASE_WORD) ^ w_inv_mask;
                                r_mem_read <= 1'b1;
                                r_state    <= ST_RD_REQ;
                            end else begin
                                r_idx       <= r_idx + 16'd1;
                                r_addr      <= w_addr_inc;
                                r_wdata     <= pat(w_addr_inc[17:2]) ^ w_inv_mask;
                                r_mem_write <= 1'b1;
                                r_state     <= ST_WR_REQ;
                            end
                        end
                    end
                    ST_RD_REQ: begin
                        if (mem_ack) begin
                            r_mem_read  <= 1'b0;
                            r_wd_reload <= 1'b1;
                            r_state     <= ST_RD_REL;
                            if (mem_read_data != r_wdata) begin
                                if (r_err == '0) begin
                                    r_fail_addr <= r_addr;
                                    r_fail_data <= mem_read_data;
                                end
                                if (r_err != '1) begin
                                    r_err <= r_err + 16'd1;
                                end
                            end
                        end
                    end
                    ST_RD_REL: begin
                        if (!mem_ack) begin
                            r_wd_reload <= 1'b1;
                            if (r_idx == LAST_IDX) begin
`ifdef MEM_BIST_INVERT_PASS_EN
                                if (!r_inv) begin
                                    r_inv       <= 1'b1;
                                    r_idx       <= '0;
                                    r_addr      <= ADDR_BASE;
                                    r_wdata     <= ~pat(BASE_WORD);
                                    r_mem_write <= 1'b1;
                                    r_state     <= ST_WR_REQ;
                                end else begin
                                    r_state <= ST_FIN;
                                end
`else
                                r_state <= ST_FIN;
`endif
                            end else begin
                                r_idx      <= r_idx + 16'd1;
                                r_addr     <= w_addr_inc;
                                r_wdata    <= pat(w_addr_inc[17:2]) ^ w_inv_mask;
                                r_mem_read <= 1'b1;
                                r_state    <= ST_RD_REQ;
                            end
                        end
                    end
                    ST_FIN: begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (r_err == '0) && !r_timeout;
                        r_state <= ST_IDLE;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign mem_read       = r_mem_read;
    assign mem_write      = r_mem_write;
    assign mem_addr       = r_addr;
    assign mem_write_data = r_wdata;
    assign busy           = r_busy;
    assign done           = r_done;
    assign pass           = r_pass;
    assign timeout        = r_timeout;
    assign err_count      = r_err;
    assign fail_addr      = r_fail_addr;
    assign fail_data      = r_fail_data;

endmodule

// File: tb/tb_mem_bist.sv
// Bench for mem_bist: responder model on the word bus, scoreboard of expected
// transactions and end-of-test results, protocol monitoring.
module tb_mem_bist;

    localparam logic [31:0] BASE  = 32'h0000_0100;
    localparam int          WORDS = 4;
    localparam int          TO    = 15;
`ifdef MEM_BIST_INVERT_PASS_EN
    localparam int NPASS = 2;
`else
    localparam int NPASS = 1;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_read_data = 32'h0;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_write_data;
    logic        busy, done, pass, timeout;
    logic [15:0] err_count;
    logic [31:0] fail_addr, fail_data;

    mem_bist #(
        .ADDR_BASE (BASE),
        .WORDS     (WORDS),
        .ADDR_STEP (32'd4),
        .TIMEOUT   (TO)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_ack        (mem_ack),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .timeout        (timeout),
        .err_count      (err_count),
        .fail_addr      (fail_addr),
        .fail_data      (fail_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    typedef struct packed {
        logic        pass;
        logic        tmo;
        logic [15:0] err;
        logic [31:0] faddr;
        logic [31:0] fdata;
    } res_t;

    txn_t sb_txn[$];
    res_t sb_res[$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s act=%h exp=%h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] tb_pat(input logic [31:0] a);
        logic [15:0] w;
        w = a[17:2];
        return {~w, w};
    endfunction

    // Responder configuration and observations
    int          rsp_lat = 0;
    int          rsp_hold = 0;
    int          rsp_noack = -1;
    logic [31:0] rsp_corrupt = 32'hFFFF_FFFF;
    int          txn_seen = 0;
    int          stall_cyc = 0;
    int          proto_viol = 0;
    logic [31:0] mem [logic [31:0]];

    task automatic rsp_ack();
        logic [31:0] d;
        mem_ack = 1'b1;
        if (mem_read) begin
            d = mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
            if (mem_addr == rsp_corrupt) d = d ^ 32'h1;
            mem_read_data = d;
        end
    endtask

    initial begin : responder
        int   phase;
        int   cnt;
        logic req;
        logic prev_req;
        logic [31:0] prev_addr, prev_wdata;
        txn_t e;
        phase = 0; cnt = 0; prev_req = 1'b0; prev_addr = '0; prev_wdata = '0;
        forever begin
            @(negedge clk);
            req = mem_read || mem_write;
            if (!reset_n) begin
                phase = 0;
                mem_ack = 1'b0;
                prev_req = 1'b0;
            end else begin
                if (mem_read && mem_write) proto_viol++;
                if (req && prev_req && (mem_addr !== prev_addr || mem_write_data !== prev_wdata)) proto_viol++;
                if (req && !prev_req && mem_ack) proto_viol++;
                case (phase)
                    0: if (req) begin
                        txn_seen++;
                        check_eq("sb_avail", 32'(sb_txn.size() != 0), 32'd1);
                        if (sb_txn.size() != 0) begin
                            e = sb_txn.pop_front();
                            check_eq("txn_kind", 32'(mem_write), 32'(e.wr));
                            check_eq("txn_addr", mem_addr, e.addr);
                            if (e.wr) check_eq("txn_wdata", mem_write_data, e.data);
                        end
                        if (mem_write) mem[mem_addr] = mem_write_data;
                        if (txn_seen - 1 == rsp_noack) begin
                            phase = 4;
                            stall_cyc = 1;
                        end else if (rsp_lat == 0) begin
                            rsp_ack();
                            phase = 2;
                        end else begin
                            cnt = rsp_lat;
                            phase = 1;
                        end
                    end
                    1: begin
                        cnt--;
                        if (cnt == 0) begin
                            rsp_ack();
                            phase = 2;
                        end
                    end
                    2: if (!req) begin
                        if (rsp_hold == 0) begin
                            mem_ack = 1'b0;
                            phase = 0;
                        end else begin
                            cnt = rsp_hold;
                            phase = 3;
                        end
                    end
                    3: begin
                        cnt--;
                        if (cnt == 0) begin
                            mem_ack = 1'b0;
                            phase = 0;
                        end
                    end
                    default: if (req) stall_cyc++; else phase = 0;
                endcase
                prev_req = req;
            end
            prev_addr = mem_addr;
            prev_wdata = mem_write_data;
        end
    end

    task automatic push_txns();
        txn_t t;
        for (int p = 0; p < NPASS; p++) begin
            for (int i = 0; i < WORDS; i++) begin
                t.wr = 1'b1;
                t.addr = BASE + 32'(i * 4);
                t.data = tb_pat(t.addr) ^ ((p == 1) ? 32'hFFFF_FFFF : 32'h0);
                sb_txn.push_back(t);
            end
            for (int i = 0; i < WORDS; i++) begin
                t.wr = 1'b0;
                t.addr = BASE + 32'(i * 4);
                t.data = 32'h0;
                sb_txn.push_back(t);
            end
        end
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_ctl"}, {26'h0, mem_read, mem_write, busy, done, pass, timeout}, 32'h0);
        check_eq({tag, "_err"}, {16'h0, err_count}, 32'h0);
        check_eq({tag, "_faddr"}, fail_addr, 32'h0);
        check_eq({tag, "_fdata"}, fail_data, 32'h0);
        check_eq({tag, "_addr"}, mem_addr | mem_write_data, 32'h0);
    endtask

    task automatic run_test(input string tag, input int lat, input int hold,
                            input logic [31:0] corrupt, input int noack,
                            input res_t exp, input int exp_txn, input int exp_stall);
        res_t r;
        logic got;
        rsp_lat = lat; rsp_hold = hold; rsp_corrupt = corrupt; rsp_noack = noack;
        txn_seen = 0; stall_cyc = 0;
        sb_txn.delete();
        push_txns();
        sb_res.push_back(exp);
        got = 1'b0;
        start = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (i == 1) check_eq({tag, "_busy"}, 32'(busy), 32'd1);
            // a second start edge while busy must not restart the sequence
            if (i == 3) start = 1'b0;
            if (i == 10) start = 1'b1;
            if (i == 12) start = 1'b0;
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        start = 1'b0;
        check_eq({tag, "_done"}, 32'(got), 32'd1);
        r = sb_res.pop_front();
        check_eq({tag, "_pass"}, 32'(pass), 32'(r.pass));
        check_eq({tag, "_tmo"}, 32'(timeout), 32'(r.tmo));
        check_eq({tag, "_err"}, 32'(err_count), 32'(r.err));
        check_eq({tag, "_faddr"}, fail_addr, r.faddr);
        check_eq({tag, "_fdata"}, fail_data, r.fdata);
        check_eq({tag, "_idle"}, 32'(busy), 32'd0);
        check_eq({tag, "_ntxn"}, 32'(txn_seen), 32'(exp_txn));
        if (exp_stall >= 0) check_eq({tag, "_stall"}, 32'(stall_cyc), 32'(exp_stall));
        repeat (5) @(negedge clk);
    endtask

    initial begin : main
        res_t e;
        logic seen;
        repeat (3) @(negedge clk);
        check_zero("rst");
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        e = '{pass: 1'b1, tmo: 1'b0, err: 16'd0, faddr: 32'h0, fdata: 32'h0};
        run_test("zw", 0, 0, 32'hFFFF_FFFF, -1, e, 2 * WORDS * NPASS, -1);

        e = '{pass: 1'b0, tmo: 1'b0, err: 16'(NPASS), faddr: 32'h108, fdata: tb_pat(32'h108) ^ 32'h1};
        run_test("corr", 0, 0, 32'h108, -1, e, 2 * WORDS * NPASS, -1);

        e = '{pass: 1'b0, tmo: 1'b1, err: 16'd0, faddr: 32'h0, fdata: 32'h0};
        run_test("tmo", 0, 0, 32'hFFFF_FFFF, 2, e, 3, TO);

        e = '{pass: 1'b1, tmo: 1'b0, err: 16'd0, faddr: 32'h0, fdata: 32'h0};
        run_test("slow", 3, 2, 32'hFFFF_FFFF, -1, e, 2 * WORDS * NPASS, -1);

        // reset in the middle of the read phase
        rsp_lat = 2; rsp_hold = 0; rsp_noack = -1; rsp_corrupt = 32'hFFFF_FFFF;
        txn_seen = 0;
        sb_txn.delete();
        push_txns();
        start = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (i == 3) start = 1'b0;
            if (mem_read) begin
                seen = 1'b1;
                break;
            end
        end
        start = 1'b0;
        check_eq("midrst_rdseen", 32'(seen), 32'd1);
        #1 reset_n = 1'b0;
        #1 check_zero("midrst");
        repeat (2) @(negedge clk);
        #1 reset_n = 1'b1;
        repeat (2) @(negedge clk);
        run_test("rerun", 0, 0, 32'hFFFF_FFFF, -1, e, 2 * WORDS * NPASS, -1);

        check_eq("proto_viol", 32'(proto_viol), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
